fp_add_pipe: RTL and testbench
==============================

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state rises on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, operand pair present.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-007 The block SHALL have ports a and b, input, W each, IEEE-754-style operands (sign, biased exponent, fraction).
REQ-008 The block SHALL have port sub, input, 1; 0 computes a+b, 1 computes a-b (b sign inverted).
REQ-009 The block SHALL have port out_valid, output, 1, result present.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 The block SHALL have port res, output, W, rounded sum.
REQ-012 The block SHALL have port flags, output, 3, {invalid, overflow, inexact} for the result in res.

Function
REQ-013 Pipeline SHALL have 3 registered stages: S1 special-case detect, magnitude compare/swap, align shift with guard/round/sticky; S2 two's-complement add/subtract of MAN_W+4-bit significands; S3 leading-zero normalise, round, pack.
REQ-014 Transfer rules: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-015 Latency SHALL be exactly 3 cycles from accept to out_valid with no stall; throughput 1 result/cycle.
REQ-016 Stall rule: adv = out_ready || !out_valid; in_ready = adv; whole pipeline holds when adv=0; res/flags/out_valid SHALL stay stable while out_valid && !out_ready.
REQ-017 Bubbles SHALL propagate as per-stage valid bits; in_valid=0 on an advance cycle inserts a bubble.
REQ-018 Swap: operand with larger {exponent,fraction} SHALL be the large operand; on exact magnitude tie a is large.
REQ-019 Align: shift amount = exponent difference; shift >= MAN_W+3 SHALL yield zero significand with sticky = OR of all small-operand significand bits.
REQ-020 Rounding SHALL be round-to-nearest-even using guard, round, sticky; mantissa carry-out from rounding SHALL increment exponent.
REQ-021 Normalisation: carry from add shifts right 1 (shifted-out bit ORed into sticky); cancellation shifts left by leading-zero count, limited so exponent does not go below 1.
REQ-022 Denormal inputs SHALL be treated as signed zero; results below the normal range SHALL flush to signed zero with inexact=1.
REQ-023 Exact cancellation (equal magnitudes, opposite effective signs) SHALL give +0; (+0)+(+0)=+0, (-0)+(-0)=-0.
REQ-024 Exponent reaching all-ones after normalise/round SHALL give signed infinity with overflow=1, inexact=1.
REQ-025 Any NaN input or inf+(-inf) SHALL give canonical quiet NaN (sign 0, exponent all ones, fraction MSB 1, rest 0) with invalid=1; inf with finite SHALL give that inf, flags 0.
REQ-026 inexact SHALL be 1 iff guard|round|sticky nonzero before rounding, or overflow/underflow flush occurred.

Reset
REQ-027 While rst_n=0, all stage valid bits, out_valid, res and flags SHALL be 0 immediately, independent of clk.
REQ-028 in_ready SHALL be 1 during and after reset (follows REQ-016 with out_valid=0).
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations; no result for them ever appears.

Verification
REQ-030 Default params, out_ready=1: a=0x3F800000, b=0x40000000, sub=0 -> 3 cycles later res=0x40400000, flags=000.
REQ-031 a=0x3F800000, b=0x3F800000, sub=1 -> res=0x00000000, flags=000; a=0x3F800001, b=0x33800000, sub=0 -> res=0x3F800002, flags=001 (tie to even).
REQ-032 a=0x7F7FFFFF, b=0x7F7FFFFF -> res=0x7F800000, flags=011; a=0x7F800000, b=0xFF800000 -> res=0x7FC00000, flags=100.
REQ-033 Stream 5 back-to-back ops, hold out_ready=0 for 4 cycles after first out_valid -> in_ready=0 while full, res held stable, all 5 results emerge in order with none lost or duplicated.
REQ-034 Assert rst_n=0 for 1 cycle with 3 ops in flight -> out_valid=0 immediately, no stale result after release; next op has 3-cycle latency.
REQ-035 Parameter sweep EXP_W=5, MAN_W=10: 0x3C00+0x4000 -> 0x4200 after 3 cycles; random compare against a golden software model.

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage pipelined floating-point adder/subtractor.
//   S1: special-case detection, magnitude compare/swap, alignment with G/R/S
//   S2: add or subtract of the aligned significands
//   S3: normalise, round to nearest even, pack result and flags
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, sub: 0 -> a+b, 1 -> a-b)
//   out_valid/out_ready result handshake (res, flags = {invalid, overflow, inexact})
// The whole pipeline advances together; it freezes only while a result is
// presented and not taken, so res/flags stay stable during back-pressure.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] res,
    output logic [2:0]           flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 4;                 // hidden + fraction + guard/round/sticky
    localparam int LZ_W = $clog2(SW + 1) + 1;
    localparam int XW   = (EXP_W + 2 > LZ_W) ? EXP_W + 2 : LZ_W;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
    localparam logic [MAN_W-1:0] MAN_ZERO = {MAN_W{1'b0}};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // Leading-zero count; the highest set bit is the last one to overwrite n.
    function automatic logic [XW-1:0] lead_zeros(input logic [SW-1:0] v);
        logic [XW-1:0] n;
        n = XW'(SW);
        for (int i = 0; i < SW; i++) begin
            n = v[i] ? XW'(SW - 1 - i) : n;
        end
        return n;
    endfunction

    logic adv;

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic             sp1_q, sp1_d, sp2_q, sp2_d;
    logic [W-1:0]     sp_res1_q, sp_res1_d, sp_res2_q, sp_res2_d;
    logic [2:0]       sp_fl1_q, sp_fl1_d, sp_fl2_q, sp_fl2_d;
    logic             sl1_q, sl1_d, ss1_q, ss1_d;
    logic [EXP_W-1:0] e1_q, e1_d, e2_q, e2_d;
    logic [SW-1:0]    sig_l1_q, sig_l1_d, sig_s1_q, sig_s1_d;
    logic             sign2_q, sign2_d, zsign2_q, zsign2_d;
    logic [SW:0]      sum2_q, sum2_d;
    logic [W-1:0]     res_q, res_d;
    logic [2:0]       flags_q, flags_d;

    logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0] ea, eb, l_exp, s_exp, diff;
    logic [MAN_W-1:0] fa, fb;
    logic [W-2:0]     key_a, key_b;
    logic [SW-1:0]    sig_a, sig_b, sig_l, sig_s, lost, aligned;
    logic             l_sign, s_sign;

    logic [XW-1:0]    e_ext, lz, lim, sh, ex, ex_r;
    logic [SW-1:0]    sum_lo, norm;
    logic             rup, inexact;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W-1:0] frac;

    assign adv       = out_ready || !v3_q;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign res       = res_q;
    assign flags     = flags_q;

    // S1: unpack, classify, order by magnitude and align the smaller operand
    always_comb begin
        sa     = a[W-1];
        sb     = b[W-1] ^ sub;
        ea     = a[W-2:MAN_W];
        eb     = b[W-2:MAN_W];
        fa     = a[MAN_W-1:0];
        fb     = b[MAN_W-1:0];
        // A zero exponent field (zero or denormal) is treated as signed zero.
        a_zero = (ea == EXP_ZERO);
        b_zero = (eb == EXP_ZERO);
        a_inf  = (ea == EXP_ONES) && (fa == MAN_ZERO);
        b_inf  = (eb == EXP_ONES) && (fb == MAN_ZERO);
        a_nan  = (ea == EXP_ONES) && (fa != MAN_ZERO);
        b_nan  = (eb == EXP_ONES) && (fb != MAN_ZERO);
        key_a  = a_zero ? {(W-1){1'b0}} : {ea, fa};
        key_b  = b_zero ? {(W-1){1'b0}} : {eb, fb};
        sig_a  = a_zero ? {SW{1'b0}} : {1'b1, fa, 3'b000};
        sig_b  = b_zero ? {SW{1'b0}} : {1'b1, fb, 3'b000};
        // On an exact magnitude tie a stays the large operand.
        if (key_a >= key_b) begin
            l_sign = sa;  s_sign = sb;  l_exp = ea;  s_exp = eb;  sig_l = sig_a;  sig_s = sig_b;
        end else begin
            l_sign = sb;  s_sign = sa;  l_exp = eb;  s_exp = ea;  sig_l = sig_b;  sig_s = sig_a;
        end
        diff = l_exp - s_exp;
        // Shifted-out bits collapse into the sticky position (bit 0).
        if (32'(diff) >= 32'(SW - 1)) begin
            lost    = sig_s;
            aligned = {{(SW-1){1'b0}}, |sig_s};
        end else begin
            lost       = sig_s & ~({SW{1'b1}} << diff);
            aligned    = sig_s >> diff;
            aligned[0] = aligned[0] | (|lost);
        end
        sp1_d     = 1'b0;
        sp_res1_d = {W{1'b0}};
        sp_fl1_d  = 3'b000;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            sp1_d     = 1'b1;
            sp_res1_d = QNAN;
            sp_fl1_d  = 3'b100;
        end else if (a_inf) begin
            sp1_d     = 1'b1;
            sp_res1_d = {sa, EXP_ONES, MAN_ZERO};
        end else if (b_inf) begin
            sp1_d     = 1'b1;
            sp_res1_d = {sb, EXP_ONES, MAN_ZERO};
        end else begin
            sp1_d     = 1'b0;
        end
        v1_d     = in_valid;
        sl1_d    = l_sign;
        ss1_d    = s_sign;
        e1_d     = l_exp;
        sig_l1_d = sig_l;
        sig_s1_d = aligned;
    end

    // S2: magnitude add/subtract; large >= aligned small so the result is non-negative
    always_comb begin
        v2_d      = v1_q;
        sp2_d     = sp1_q;
        sp_res2_d = sp_res1_q;
        sp_fl2_d  = sp_fl1_q;
        sign2_d   = sl1_q;
        // Exact cancellation of opposite signs yields +0; equal signs keep their sign.
        zsign2_d  = sl1_q & ss1_q;
        e2_d      = e1_q;
        if (sl1_q != ss1_q) begin
            sum2_d = {1'b0, sig_l1_q} + {1'b1, ~sig_s1_q} + {{SW{1'b0}}, 1'b1};
        end else begin
            sum2_d = {1'b0, sig_l1_q} + {1'b0, sig_s1_q};
        end
    end

    // S3: normalise, round to nearest even, detect overflow/underflow, pack
    always_comb begin
        e_ext  = XW'(e2_q);
        sum_lo = sum2_q[SW-1:0];
        lz     = lead_zeros(sum_lo);
        lim    = (e_ext > XW'(1)) ? e_ext - XW'(1) : {XW{1'b0}};
        sh     = {XW{1'b0}};
        if (sum2_q[SW]) begin
            norm    = sum2_q[SW:1];
            norm[0] = sum2_q[1] | sum2_q[0];
            ex      = e_ext + XW'(1);
        end else begin
            // Left shift is capped so the exponent never drops below 1.
            sh   = (lz < lim) ? lz : lim;
            norm = sum_lo << sh;
            ex   = e_ext - sh;
        end
        rup     = norm[2] & (norm[1] | norm[0] | norm[3]);
        inexact = |norm[2:0];
        rnd     = {1'b0, norm[SW-1:3]} + {{(MAN_W+1){1'b0}}, rup};
        ex_r    = rnd[MAN_W+1] ? ex + XW'(1) : ex;
        frac    = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        v3_d    = v2_q;
        if (sp2_q) begin
            res_d   = sp_res2_q;
            flags_d = sp_fl2_q;
        end else if (sum2_q == {(SW+1){1'b0}}) begin
            res_d   = {zsign2_q, {(W-1){1'b0}}};
            flags_d = 3'b000;
        end else if (!norm[SW-1]) begin
            // Still unnormalised at the minimum exponent: below normal range.
            res_d   = {sign2_q, {(W-1){1'b0}}};
            flags_d = 3'b001;
        end else if (ex_r >= XW'(EXP_ONES)) begin
            res_d   = {sign2_q, EXP_ONES, MAN_ZERO};
            flags_d = 3'b011;
        end else begin
            res_d   = {sign2_q, ex_r[EXP_W-1:0], frac};
            flags_d = {2'b00, inexact};
        end
    end

    // Pipeline registers: cleared asynchronously, all stages move together on adv
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;          v2_q      <= 1'b0;          v3_q     <= 1'b0;
            sp1_q     <= 1'b0;          sp2_q     <= 1'b0;
            sp_res1_q <= {W{1'b0}};     sp_res2_q <= {W{1'b0}};
            sp_fl1_q  <= 3'b000;        sp_fl2_q  <= 3'b000;
            sl1_q     <= 1'b0;          ss1_q     <= 1'b0;
            e1_q      <= {EXP_W{1'b0}}; e2_q      <= {EXP_W{1'b0}};
            sig_l1_q  <= {SW{1'b0}};    sig_s1_q  <= {SW{1'b0}};
            sign2_q   <= 1'b0;          zsign2_q  <= 1'b0;
            sum2_q    <= {(SW+1){1'b0}};
            res_q     <= {W{1'b0}};     flags_q   <= 3'b000;
        end else if (adv) begin
            v1_q      <= v1_d;          v2_q      <= v2_d;          v3_q     <= v3_d;
            sp1_q     <= sp1_d;         sp2_q     <= sp2_d;
            sp_res1_q <= sp_res1_d;     sp_res2_q <= sp_res2_d;
            sp_fl1_q  <= sp_fl1_d;      sp_fl2_q  <= sp_fl2_d;
            sl1_q     <= sl1_d;         ss1_q     <= ss1_d;
            e1_q      <= e1_d;          e2_q      <= e2_d;
            sig_l1_q  <= sig_l1_d;      sig_s1_q  <= sig_s1_d;
            sign2_q   <= sign2_d;       zsign2_q  <= zsign2_d;
            sum2_q    <= sum2_d;
            res_q     <= res_d;         flags_q   <= flags_d;
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed testbench for fp_add_pipe: single-precision and half-precision
// instances, latency, back-pressure streaming and mid-flight reset.
module tb_fp_add_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a_i, b_i, res;
    logic [2:0]  flags;
    logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_res;
    logic [2:0]  h_flags;

    int checks   = 0;
    int failures = 0;
    int sent, got, hold;
    logic seen;
    logic [31:0] st_a [5];
    logic [31:0] st_b [5];
    logic [31:0] st_e [5];

    fp_add_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .flags(flags)
    );

    fp_add_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .res(h_res), .flags(h_flags)
    );

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
        end
    endtask

    // One isolated single-precision op: checks ready, exact 3-cycle latency, result and flags.
    task automatic run_sp(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vs, input logic [31:0] er, input logic [2:0] ef);
        @(negedge clk);
        a_i = va; b_i = vb; sub = vs; in_valid = 1'b1;
        #1 chk($sformatf("%s_rdy", tag), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_lat", tag), 32'(out_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("%s_vld", tag), 32'(out_valid), 32'd1);
        chk($sformatf("%s_res", tag), res, er);
        chk($sformatf("%s_flg", tag), 32'(flags), 32'(ef));
    endtask

    // Same for the half-precision instance.
    task automatic run_h(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vs, input logic [15:0] er, input logic [2:0] ef);
        @(negedge clk);
        h_a = va; h_b = vb; h_sub = vs; h_in_valid = 1'b1;
        @(negedge clk);
        h_in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_lat", tag), 32'(h_out_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("%s_vld", tag), 32'(h_out_valid), 32'd1);
        chk($sformatf("%s_res", tag), 32'(h_res), 32'(er));
        chk($sformatf("%s_flg", tag), 32'(h_flags), 32'(ef));
    endtask

    initial begin
        st_a = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h40800000};
        st_b = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'hBF800000, 32'h3F800000};
        st_e = '{32'h40400000, 32'h40800000, 32'h40000000, 32'h3F800000, 32'h40A00000};
        rst_n = 1'b0; in_valid = 1'b0; a_i = 32'h0; b_i = 32'h0; sub = 1'b0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = 16'h0; h_b = 16'h0; h_sub = 1'b0; h_out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_res", res, 32'h0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_h_valid", 32'(h_out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_sp("add_1_2",    32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        run_sp("sub_equal",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        run_sp("tie_up",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
        run_sp("tie_down",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        run_sp("round_bit",  32'h3F800000, 32'h33000000, 1'b0, 32'h3F800000, 3'b001);
        run_sp("far_shift",  32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b001);
        run_sp("carry_rnd",  32'h3FFFFFFF, 32'h3F800000, 1'b0, 32'h40400000, 3'b001);
        run_sp("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        run_sp("inf_m_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
        run_sp("nan_in",     32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        run_sp("inf_fin",    32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
        run_sp("negz_negz",  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        run_sp("posz_m_z",   32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000);
        run_sp("denorm_in",  32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
        run_sp("cancel_2_1", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000);
        run_sp("swap_neg",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
        run_sp("underflow",  32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);

        run_h("h_add",  16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000);
        run_h("h_sub",  16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000);
        run_h("h_tie",  16'h3C01, 16'h1000, 1'b0, 16'h3C02, 3'b001);
        run_h("h_ovf",  16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b011);
        run_h("h_nan",  16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b100);

        // Back-to-back stream with a 4-cycle consumer stall after the first result.
        sent = 0; got = 0; hold = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                hold = 4;
            end
            out_ready = (hold == 0);
            if (sent < 5) begin
                a_i = st_a[sent]; b_i = st_b[sent]; sub = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold > 0) begin
                chk("stall_ready", 32'(in_ready), 32'd0);
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_res", res, st_e[got]);
                hold--;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk($sformatf("stream_res%0d", got), res, st_e[got]);
                got++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 32'(got), 32'd5);
        chk("stream_sent", 32'(sent), 32'd5);
        repeat (4) begin
            @(negedge clk);
            chk("stream_drain", 32'(out_valid), 32'd0);
        end

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_i = st_a[i]; b_i = st_b[i]; sub = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_res", res, 32'h0);
        chk("mid_rst_flags", 32'(flags), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
        end
        run_sp("post_rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
